// File: rtl/param_fifo_pkg.sv
// Shared constants and sizing helper for the parameterised FIFO.
package param_fifo_pkg;
  localparam int DATA_WIDTH_DEF = 8;
  localparam int ADDR_WIDTH_DEF = 4;

  function automatic int depth(input int aw);
    return 1 << aw;
  endfunction
endpackage

// File: rtl/param_fifo_if.sv
// Producer/consumer handshake bundle; master drives requests, slave is the FIFO.
interface param_fifo_if
  import param_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
);
  logic                  wr_en;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] din;
  logic [DATA_WIDTH-1:0] dout;
  logic                  full;
  logic                  empty;

  modport master (output wr_en, rd_en, din, input dout, full, empty);
  modport slave  (input wr_en, rd_en, din, output dout, full, empty);
endinterface

// File: rtl/param_fifo_core.sv
// FIFO storage, binary wrap-bit pointers, status flags and registered read port.
module param_fifo_core
  import param_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty
);
  localparam int PW = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] mem [0:depth(ADDR_WIDTH)-1];
  logic [PW-1:0]         wr_ptr_bin_q, wr_ptr_bin_d;
  logic [PW-1:0]         rd_ptr_bin_q, rd_ptr_bin_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  wr_acc, rd_acc;

  // Equal low bits with differing wrap bits means the writer lapped the reader.
  always_comb begin
    empty        = (wr_ptr_bin_q == rd_ptr_bin_q);
    full         = (wr_ptr_bin_q[ADDR_WIDTH] != rd_ptr_bin_q[ADDR_WIDTH]) &&
                   (wr_ptr_bin_q[ADDR_WIDTH-1:0] == rd_ptr_bin_q[ADDR_WIDTH-1:0]);
    wr_acc       = wr_en && !full;
    rd_acc       = rd_en && !empty;
    wr_ptr_bin_d = wr_ptr_bin_q + PW'(wr_acc);
    rd_ptr_bin_d = rd_ptr_bin_q + PW'(rd_acc);
    dout_d       = dout_q;
    if (rd_acc) dout_d = mem[rd_ptr_bin_q[ADDR_WIDTH-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_bin_q <= '0;
      rd_ptr_bin_q <= '0;
      dout_q       <= '0;
    end else begin
      wr_ptr_bin_q <= wr_ptr_bin_d;
      rd_ptr_bin_q <= rd_ptr_bin_d;
      dout_q       <= dout_d;
    end
  end

  // Storage is never cleared; reset only discards it through the pointers.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) mem[wr_ptr_bin_q[ADDR_WIDTH-1:0]] <= din;
  end

  assign dout = dout_q;
endmodule

// File: rtl/param_fifo.sv
// Thin wrapper binding the handshake interface onto the FIFO core.
module param_fifo
  import param_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic         clk,
  input  logic         rst,
  param_fifo_if.slave  bus
);
  param_fifo_core #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_core (
    .clk   (clk),
    .rst   (rst),
    .wr_en (bus.wr_en),
    .rd_en (bus.rd_en),
    .din   (bus.din),
    .dout  (bus.dout),
    .full  (bus.full),
    .empty (bus.empty)
  );
endmodule

// File: tb/tb_param_fifo.sv
// Directed bench for param_fifo: queue model checked every cycle plus literal spot checks.
module tb_param_fifo;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  param_fifo_if #(.DATA_WIDTH(DW)) bus ();

  param_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference: occupancy queue plus last read word.
  logic [DW-1:0] m_q [$];
  logic [DW-1:0] m_dout = '0;
  bit            chk_en = 1'b0;

  always @(posedge clk) begin
    bit rd_ok, wr_ok;
    if (rst) begin
      m_q.delete();
      m_dout = '0;
      chk_en = 1'b1;
    end else begin
      rd_ok = bus.rd_en && (m_q.size() != 0);
      wr_ok = bus.wr_en && (m_q.size() != DEPTH);
      if (rd_ok) m_dout = m_q.pop_front();
      if (wr_ok) m_q.push_back(bus.din);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_empty", 32'(bus.empty), 32'(m_q.size() == 0));
      chk("model_full",  32'(bus.full),  32'(m_q.size() == DEPTH));
      chk("model_dout",  32'(bus.dout),  32'(m_dout));
    end
  end

  // Inputs change 1ns after a rising edge, apply at the next edge, results read 1ns later.
  task automatic step(input logic w, input logic r, input logic [DW-1:0] d);
    bus.wr_en = w;
    bus.rd_en = r;
    bus.din   = d;
    @(posedge clk);
    #1;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
  endtask

  initial begin
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.din   = '0;
    #1;

    rst = 1'b1;
    step(0, 0, 0);
    step(0, 0, 0);
    chk("rst_empty", 32'(bus.empty), 1);
    chk("rst_full",  32'(bus.full),  0);
    chk("rst_dout",  32'(bus.dout),  0);
    rst = 1'b0;
    step(0, 0, 0);
    chk("idle_empty", 32'(bus.empty), 1);

    // Fill and drain
    for (int i = 0; i < DEPTH; i++) begin
      step(1, 0, DW'(i));
      if (i == DEPTH - 2) chk("fill_not_full", 32'(bus.full), 0);
    end
    chk("fill_full", 32'(bus.full), 1);
    for (int i = 0; i < DEPTH; i++) begin
      step(0, 1, 0);
      chk("drain_dout", 32'(bus.dout), 32'(i));
    end
    chk("drain_empty", 32'(bus.empty), 1);

    // Overflow
    for (int i = 0; i < DEPTH; i++) step(1, 0, DW'(8'hA0 + i));
    step(1, 0, 8'hFF);
    chk("ovf_full", 32'(bus.full), 1);
    for (int i = 0; i < DEPTH; i++) begin
      step(0, 1, 0);
      chk("ovf_dout", 32'(bus.dout), 32'(8'hA0 + i));
    end
    chk("ovf_empty", 32'(bus.empty), 1);

    // Underflow
    step(1, 0, 8'h5C);
    step(0, 1, 0);
    chk("udf_prime", 32'(bus.dout), 32'h5C);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0);
      chk("udf_hold", 32'(bus.dout), 32'h5C);
      chk("udf_empty", 32'(bus.empty), 1);
    end
    step(1, 0, 8'h11);
    step(0, 1, 0);
    chk("udf_ptrs", 32'(bus.dout), 32'h11);

    // Simultaneous read/write with wrap
    for (int i = 0; i < 8; i++) step(1, 0, DW'(8'h40 + i));
    for (int k = 0; k < 20; k++) begin
      step(1, 1, DW'(8'h48 + k));
      chk("sim_dout",  32'(bus.dout),  32'(8'h40 + k));
      chk("sim_full",  32'(bus.full),  0);
      chk("sim_empty", 32'(bus.empty), 0);
    end
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 0);
      chk("sim_tail", 32'(bus.dout), 32'(8'h54 + i));
    end
    chk("sim_done_empty", 32'(bus.empty), 1);

    // Simultaneous on empty: write only, no bypass
    step(1, 1, 8'h22);
    chk("se_nobypass", 32'(bus.dout), 32'h5B);
    chk("se_empty", 32'(bus.empty), 0);
    step(0, 1, 0);
    chk("se_read", 32'(bus.dout), 32'h22);

    // Simultaneous on full: read only, write dropped
    for (int i = 0; i < DEPTH; i++) step(1, 0, DW'(8'h80 + i));
    step(1, 1, 8'hEE);
    chk("sf_dout", 32'(bus.dout), 32'h80);
    chk("sf_full", 32'(bus.full), 0);
    for (int i = 1; i < DEPTH; i++) begin
      step(0, 1, 0);
      chk("sf_drain", 32'(bus.dout), 32'(8'h80 + i));
    end
    chk("sf_empty", 32'(bus.empty), 1);

    // Reset mid-stream with a read in flight
    for (int i = 0; i < 5; i++) step(1, 0, DW'(8'h70 + i));
    step(0, 1, 0);
    step(0, 1, 0);
    chk("mid_dout", 32'(bus.dout), 32'h71);
    rst = 1'b1;
    step(0, 1, 0);
    chk("mid_rst_empty", 32'(bus.empty), 1);
    chk("mid_rst_dout",  32'(bus.dout),  0);
    rst = 1'b0;
    step(1, 0, 8'h3C);
    step(0, 1, 0);
    chk("mid_after", 32'(bus.dout), 32'h3C);
    chk("mid_after_empty", 32'(bus.empty), 1);

    step(0, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
